// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
// Optional feature macro used by the unit: MULDIV_HILO_WRITE_EN (MTHI/MTLO port).
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    // Op bit 1 selects divide; bit 0 clear means the op is signed.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// muldiv_abs: combinational conditional two's-complement negate.
// Gives |x| when neg is driven with the sign bit of a signed operand,
// and applies the result sign correction when driven with a sign flag.
module muldiv_abs
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
// Optional MTHI/MTLO write port enabled by defining MULDIV_HILO_WRITE_EN.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after FIX
// CALC  | one product/quotient bit per cycle, ITER cycles
// FIX   | sign correction of the magnitude result, HI/LO write
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MULDIV_HILO_WRITE_EN
    input  logic [31:0] hilo_wdata,
    input  logic        hi_we,
    input  logic        lo_we,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_t state_q, state_d;

    logic          is_div_q;
    logic          sign_a_q;
    logic          sign_b_q;
    logic [31:0]   opnd_q;
    logic [63:0]   acc_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;

    logic          load;
    logic          step;
    logic          fix_wr;

    // Start-time operand conditioning.
    logic          op_signed;
    logic          op_div;
    logic          div_zero;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;

    assign op_signed = md_is_signed(op);
    assign op_div    = md_is_div(op);
    assign div_zero  = op_div & (b == 32'd0);

    muldiv_abs #(.W(32)) u_abs_a (.x(a), .neg(op_signed & a[31]), .y(mag_a));
    muldiv_abs #(.W(32)) u_abs_b (.x(b), .neg(op_signed & b[31]), .y(mag_b));

    // One iteration step. Multiply keeps the multiplier in acc[31:0] and
    // accumulates into the upper half, shifting right; divide keeps the
    // dividend/quotient in acc[31:0] and the partial remainder above it,
    // shifting left.
    logic [32:0]   mul_sum;
    logic [32:0]   div_trial;
    logic          div_ge;
    logic [31:0]   div_diff;
    logic [63:0]   acc_step;

    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign div_trial = acc_q[63:31];
    assign div_ge    = div_trial >= {1'b0, opnd_q};
    assign div_diff  = div_trial[31:0] - opnd_q;
    assign acc_step  = is_div_q
                     ? {(div_ge ? div_diff : div_trial[31:0]), acc_q[30:0], div_ge}
                     : {mul_sum, acc_q[31:1]};

    // Result sign correction. Sign flags are zero for unsigned ops and for
    // divide-by-zero, so those pass through untouched.
    logic [63:0]   prod_fix;
    logic [31:0]   quo_fix;
    logic [31:0]   rem_fix;

    muldiv_abs #(.W(64)) u_fix_prod (.x(acc_q),         .neg(sign_a_q ^ sign_b_q), .y(prod_fix));
    muldiv_abs #(.W(32)) u_fix_quo  (.x(acc_q[31:0]),   .neg(sign_a_q ^ sign_b_q), .y(quo_fix));
    muldiv_abs #(.W(32)) u_fix_rem  (.x(acc_q[63:32]),  .neg(sign_a_q),            .y(rem_fix));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = div_zero ? FIX : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_d = FIX;
            end
            FIX: begin
                fix_wr  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, iteration counter and shared accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= '0;
        end else if (load) begin
            is_div_q <= op_div;
            cnt_q    <= '0;
            if (div_zero) begin
                // FIX then writes hi = a unmodified, lo = all ones.
                sign_a_q <= 1'b0;
                sign_b_q <= 1'b0;
                opnd_q   <= 32'd0;
                acc_q    <= {a, 32'hFFFF_FFFF};
            end else begin
                sign_a_q <= op_signed & a[31];
                sign_b_q <= op_signed & b[31];
                opnd_q   <= op_div ? mag_b : mag_a;
                acc_q    <= {32'd0, (op_div ? mag_a : mag_b)};
            end
        end else if (step) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Done pulse: the cycle right after the FIX write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= fix_wr;
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (fix_wr) begin
            if (is_div_q) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else begin
                hi_q <= prod_fix[63:32];
                lo_q <= prod_fix[31:0];
            end
        end
`ifdef MULDIV_HILO_WRITE_EN
        else if (state_q == IDLE && !start) begin
            if (hi_we) hi_q <= hilo_wdata;
            if (lo_we) lo_q <= hilo_wdata;
        end
`endif
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (native multiply, divide and modulo).
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULDIV_HILO_WRITE_EN
    logic [31:0] hilo_wdata;
    logic        hi_we;
    logic        lo_we;
`endif

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
`ifdef MULDIV_HILO_WRITE_EN
        .hilo_wdata (hilo_wdata),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
`endif
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain arithmetic on the architectural values.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] ehi, output logic [31:0] elo, output int elat);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        elat = 33;
        case (o)
            2'b00: begin
                p = 64'(sx * sy);
                ehi = p[63:32]; elo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, x} * {32'd0, y};
                ehi = p[63:32]; elo = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    ehi = x; elo = 32'hFFFF_FFFF; elat = 1;
                end else if (o == 2'b10) begin
                    q = sx / sy; r = sx % sy;
                    p = 64'(q); elo = p[31:0];
                    p = 64'(r); ehi = p[31:0];
                end else begin
                    ehi = x % y; elo = x / y;
                end
            end
        endcase
    endtask

    logic [31:0] last_hi, last_lo;

    // Issue one op and wait for done; poke > 0 pulses a competing start
    // that must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int poke);
        logic [31:0] ehi, elo;
        int          elat, n;
        bit          got;
        model(o, x, y, ehi, elo, elat);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        chk("busy_after_start", 64'(busy), 64'd1);
        n = 0; got = 0;
        while (!got && n < 100) begin
            if (n == poke) begin
                start = 1'b1; op = ~o; a = $urandom; b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
        end
        start = 1'b0;
        chk($sformatf("latency op%0d", o), 64'(n), 64'(elat));
        chk("busy_low_at_done", 64'(busy), 64'd0);
        chk($sformatf("hi op%0d %h/%h", o, x, y), 64'(hi), 64'(ehi));
        chk($sformatf("lo op%0d %h/%h", o, x, y), 64'(lo), 64'(elo));
        last_hi = ehi; last_lo = elo;
    endtask

    initial begin
        bit seen_done;
        logic [31:0] rx, ry;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
`ifdef MULDIV_HILO_WRITE_EN
        hilo_wdata = 32'd0; hi_we = 1'b0; lo_we = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'b00, 32'd7,          32'hFFFF_FFFD, -1);
        run_op(2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, -1);
        run_op(2'b10, 32'hFFFF_FFF9,  32'd2,         -1);
        run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, -1);
        run_op(2'b11, 32'd123,        32'd0,         -1);
        run_op(2'b10, 32'hFFFF_FFF9,  32'd0,         -1);
        run_op(2'b11, 32'hFFFF_FFFF,  32'd1,         -1);

        repeat (5) @(posedge clk);
        #1;
        chk("hold_hi", 64'(hi), 64'(last_hi));
        chk("hold_lo", 64'(lo), 64'(last_lo));

        for (int i = 0; i < 30; i++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 3))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 9)) ^ {32{ry[31]}};
                default: ;
            endcase
            run_op(2'($urandom_range(0, 3)), rx, ry, -1);
        end

        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5);

        op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midop_reset_busy", 64'(busy), 64'd0);
        chk("midop_reset_hi",   64'(hi),   64'd0);
        chk("midop_reset_lo",   64'(lo),   64'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1;
        end
        chk("no_done_after_reset", 64'(seen_done), 64'd0);

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
